// File: rtl/root_fanin_pkg.sv
// Shared types and defaults for the hierarchy fan-in collector.
package root_fanin_pkg;

    localparam int DEF_N_CHILD = 5;
    localparam int DEF_DATA_W  = 32;
    localparam int DEF_CNT_W   = 16;
    localparam int DEF_IDX_W   = $clog2(DEF_N_CHILD);

    // Queue entry shape at default widths; the collector builds the same shape from its parameters.
    typedef struct packed {
        logic [DEF_DATA_W-1:0] data;
        logic [DEF_IDX_W-1:0]  src;
    } entry_t;

    // Reset value of the round-robin pointer: last child, so child 0 wins first.
    function automatic int unsigned last_grant_rst(input int unsigned n);
        return n - 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker; search starts one past last_grant and wraps.
module rr_arbiter #(
    parameter  int N  = 5,
    localparam int IW = $clog2(N)
) (
    input  logic [N-1:0]  req_i,
    input  logic          en_i,
    input  logic [IW-1:0] last_grant_i,
    output logic [N-1:0]  gnt_o,
    output logic [IW-1:0] gnt_idx_o
);

    always_comb begin
        int          idx;
        logic        found;
        logic [IW-1:0] sel;
        gnt_o     = '0;
        gnt_idx_o = last_grant_i;
        found     = 1'b0;
        idx       = 0;
        sel       = '0;
        for (int k = 1; k <= N; k++) begin
            idx = int'(last_grant_i) + k;
            if (idx >= N) idx = idx - N;
            sel = IW'(idx);
            if (!found && req_i[sel]) begin
                found     = 1'b1;
                gnt_idx_o = sel;
            end
        end
        if (found && en_i) gnt_o[gnt_idx_o] = 1'b1;
    end

endmodule

// File: rtl/root_fanin_collector.sv
// Merges N_CHILD valid/ready streams into one tagged stream through a 2-entry FIFO,
// with round-robin fairness and saturating per-child accept counters.
module root_fanin_collector
    import root_fanin_pkg::*;
#(
    parameter  int N_CHILD = DEF_N_CHILD,
    parameter  int DATA_W  = DEF_DATA_W,
    parameter  int CNT_W   = DEF_CNT_W,
    localparam int IDX_W   = $clog2(N_CHILD)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [N_CHILD-1:0]         child_valid,
    input  logic [N_CHILD*DATA_W-1:0]  child_data,
    output logic [N_CHILD-1:0]         child_ready,
    output logic                       up_valid,
    input  logic                       up_ready,
    output logic [DATA_W-1:0]          up_data,
    output logic [IDX_W-1:0]           up_src,
    output logic [N_CHILD*CNT_W-1:0]   grant_cnt,
    input  logic                       cnt_clear
);

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [IDX_W-1:0]  src;
    } ent_t;

    logic [1:0]                    occ_q, occ_d;
    ent_t [1:0]                    ent_q, ent_d;
    logic [IDX_W-1:0]              last_q, last_d;
    logic [N_CHILD-1:0][CNT_W-1:0] cnt_q, cnt_d;

    logic [N_CHILD-1:0] gnt;
    logic [IDX_W-1:0]   gnt_idx;
    logic               arb_en, push, pop, wr_slot;
    ent_t               new_ent;

    // Readiness depends only on registered occupancy, never on up_ready; held low in reset.
    assign arb_en = rst_n & (occ_q != 2'd2);

    rr_arbiter #(.N(N_CHILD)) u_arb (
        .req_i        (child_valid),
        .en_i         (arb_en),
        .last_grant_i (last_q),
        .gnt_o        (gnt),
        .gnt_idx_o    (gnt_idx)
    );

    assign push         = |gnt;
    assign pop          = up_valid & up_ready;
    assign new_ent.data = child_data[gnt_idx*DATA_W +: DATA_W];
    assign new_ent.src  = gnt_idx;
    // Tail slot after an optional same-cycle pop: slot 1 only when one entry stays put.
    assign wr_slot      = (occ_q == 2'd1) && !pop;

    always_comb begin
        occ_d  = occ_q;
        ent_d  = ent_q;
        last_d = last_q;
        cnt_d  = cnt_q;
        if (pop) ent_d[0] = ent_q[1];
        if (push) begin
            ent_d[wr_slot] = new_ent;
            last_d         = gnt_idx;
        end
        case ({push, pop})
            2'b10:   occ_d = occ_q + 2'd1;
            2'b01:   occ_d = occ_q - 2'd1;
            default: occ_d = occ_q;
        endcase
        for (int i = 0; i < N_CHILD; i++) begin
            if (cnt_clear)
                cnt_d[i] = '0;
            else if (gnt[i] && (cnt_q[i] != {CNT_W{1'b1}}))
                cnt_d[i] = cnt_q[i] + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            occ_q  <= '0;
            ent_q  <= '0;
            last_q <= IDX_W'(last_grant_rst(N_CHILD));
            cnt_q  <= '0;
        end else begin
            occ_q  <= occ_d;
            ent_q  <= ent_d;
            last_q <= last_d;
            cnt_q  <= cnt_d;
        end
    end

    assign child_ready = gnt;
    assign up_valid    = (occ_q != 2'd0);
    assign up_data     = ent_q[0].data;
    assign up_src      = ent_q[0].src;
    assign grant_cnt   = cnt_q;

endmodule

// File: tb/tb_root_fanin_collector.sv
// Directed + randomized bench for root_fanin_collector against a queue-based reference model.
module tb_root_fanin_collector;

    localparam int N  = 5;
    localparam int DW = 32;
    localparam int CW = 4;
    localparam int IW = $clog2(N);

    logic              clk = 1'b0;
    logic              rst_n;
    logic [N-1:0]      child_valid;
    logic [N*DW-1:0]   child_data;
    logic [N-1:0]      child_ready;
    logic              up_valid;
    logic              up_ready;
    logic [DW-1:0]     up_data;
    logic [IW-1:0]     up_src;
    logic [N*CW-1:0]   grant_cnt;
    logic              cnt_clear;

    root_fanin_collector #(.N_CHILD(N), .DATA_W(DW), .CNT_W(CW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .child_valid (child_valid),
        .child_data  (child_data),
        .child_ready (child_ready),
        .up_valid    (up_valid),
        .up_ready    (up_ready),
        .up_data     (up_data),
        .up_src      (up_src),
        .grant_cnt   (grant_cnt),
        .cnt_clear   (cnt_clear)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // Reference model state
    logic [N-1:0]         pend;
    logic [N-1:0][DW-1:0] pdata;
    logic [DW-1:0]        qd[$];
    int                   qs[$];
    int                   mlast;
    int                   mcnt[N];
    logic [N-1:0]         last_rdy;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [N*CW-1:0] model_cnt();
        logic [N*CW-1:0] v;
        v = '0;
        for (int i = 0; i < N; i++) v[i*CW +: CW] = CW'(mcnt[i]);
        return v;
    endfunction

    task automatic model_reset();
        qd.delete();
        qs.delete();
        mlast = N - 1;
        for (int i = 0; i < N; i++) mcnt[i] = 0;
    endtask

    // One clock: drive children, check combinational/registered outputs, then advance model.
    task automatic step();
        int a;
        logic [N-1:0] exp_rdy;
        @(negedge clk);
        child_valid = pend;
        child_data  = pdata;
        #1;
        a = -1;
        if (qd.size() < 2)
            for (int k = 1; k <= N; k++)
                if (a < 0 && pend[(mlast + k) % N]) a = (mlast + k) % N;
        exp_rdy = '0;
        if (a >= 0) exp_rdy[a] = 1'b1;
        last_rdy = child_ready;
        chk("child_ready", 64'(child_ready), 64'(exp_rdy));
        chk("up_valid", 64'(up_valid), 64'(qd.size() != 0));
        if (qd.size() != 0) begin
            chk("up_data", 64'(up_data), 64'(qd[0]));
            chk("up_src", 64'(up_src), 64'(qs[0]));
        end
        chk("grant_cnt", 64'(grant_cnt), 64'(model_cnt()));
        @(posedge clk);
        if (qd.size() != 0 && up_ready) begin
            void'(qd.pop_front());
            void'(qs.pop_front());
        end
        if (a >= 0) begin
            qd.push_back(pdata[a]);
            qs.push_back(a);
            mlast = a;
            pend[a] = 1'b0;
        end
        if (cnt_clear) for (int i = 0; i < N; i++) mcnt[i] = 0;
        else if (a >= 0 && mcnt[a] < (1 << CW) - 1) mcnt[a]++;
        #1;
    endtask

    task automatic drain();
        up_ready  = 1'b1;
        cnt_clear = 1'b0;
        for (int n = 0; n < 50 && (pend != 0 || qd.size() != 0); n++) step();
        chk("drain_timeout", 64'(pend != 0 || qd.size() != 0), 64'd0);
    endtask

    initial begin
        rst_n       = 1'b0;
        child_valid = '1;
        child_data  = '0;
        up_ready    = 1'b1;
        cnt_clear   = 1'b0;
        pend        = '0;
        pdata       = '0;
        model_reset();
        #12;
        chk("rst_up_valid", 64'(up_valid), 64'd0);
        chk("rst_child_ready", 64'(child_ready), 64'd0);
        chk("rst_up_data", 64'(up_data), 64'd0);
        chk("rst_up_src", 64'(up_src), 64'd0);
        chk("rst_grant_cnt", 64'(grant_cnt), 64'd0);
        child_valid = '0;
        #10 rst_n = 1'b1;

        // Reset priority: all children continuously valid, grants rotate 0..4
        for (int k = 0; k < 12; k++) begin
            for (int i = 0; i < N; i++)
                if (!pend[i]) begin pend[i] = 1'b1; pdata[i] = $urandom; end
            step();
            chk("rr_order", 64'(last_rdy), 64'(1 << (k % N)));
        end
        drain();

        // Wrap and idle: grant 4, idle, then 0 and 4 valid -> 0 wins
        pend[4] = 1'b1; pdata[4] = 32'h4444_0004;
        step();
        chk("wrap_g4", 64'(last_rdy), 64'h10);
        pend = '0;
        repeat (3) step();
        pend = 5'b10001; pdata[0] = 32'h0000_0A00; pdata[4] = 32'h0000_0A04;
        step();
        chk("wrap_g0", 64'(last_rdy), 64'h01);
        drain();

        // Backpressure: children 1 and 3, up_ready low
        up_ready = 1'b0;
        pend = 5'b01010; pdata[1] = 32'h0000_00A1; pdata[3] = 32'h0000_00A3;
        repeat (3) step();
        chk("bp_ready_low", 64'(last_rdy), 64'd0);
        chk("bp_head", 64'(up_data), 64'h0000_00A1);
        up_ready = 1'b1;
        step();
        chk("bp_second", 64'(up_src), 64'd3);
        drain();

        // Clear race with an accept from child 1
        pend[1] = 1'b1; pdata[1] = 32'hC1EA_0001;
        cnt_clear = 1'b1;
        step();
        cnt_clear = 1'b0;
        chk("clr_race_cnt1", 64'(grant_cnt[1*CW +: CW]), 64'd0);
        chk("clr_race_msg", 64'(up_data), 64'hC1EA_0001);
        drain();

        // Saturation: clear, then child 2 sends 20 messages
        cnt_clear = 1'b1;
        step();
        cnt_clear = 1'b0;
        for (int k = 0; k < 20; k++) begin
            pend[2] = 1'b1; pdata[2] = $urandom;
            step();
        end
        chk("sat_cnt", 64'(grant_cnt), 64'h00F00);
        drain();

        // Reset mid-traffic with occ=2
        up_ready = 1'b0;
        pend = 5'b01010; pdata[1] = $urandom; pdata[3] = $urandom;
        repeat (3) step();
        pend = '1;
        for (int i = 0; i < N; i++) pdata[i] = $urandom;
        child_valid = pend;
        child_data  = pdata;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_up_valid", 64'(up_valid), 64'd0);
        chk("mid_rst_ready", 64'(child_ready), 64'd0);
        chk("mid_rst_cnt", 64'(grant_cnt), 64'd0);
        model_reset();
        #2 rst_n = 1'b1;
        up_ready = 1'b1;
        step();
        chk("mid_rst_prio0", 64'(last_rdy), 64'h01);

        // Randomized traffic
        for (int k = 0; k < 400; k++) begin
            for (int i = 0; i < N; i++)
                if (!pend[i] && $urandom_range(0, 2) == 0) begin
                    pend[i] = 1'b1; pdata[i] = $urandom;
                end
            up_ready  = ($urandom_range(0, 3) != 0);
            cnt_clear = ($urandom_range(0, 15) == 0);
            step();
        end
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
